// File: rtl/add_sub_pkg.sv
// Shared types and constants for the add/sub result checker.
package add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/add_sub_golden.sv
// Golden model of the WIDTH-bit add/subtract unit: result, carry and signed overflow.
module add_sub_golden #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] exp_res,
  output logic             exp_c,
  output logic             exp_v
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   s;

  // Subtract as a + ~b + 1, so carry means "no borrow".
  always_comb begin
    b_eff   = mode ? ~b : b;
    s       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, mode};
    exp_res = s[WIDTH-1:0];
    exp_c   = s[WIDTH];
    exp_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (exp_res[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/add_sub_result_checker.sv
// Session-based checker: compares DUT responses against the golden model,
// counts passes/fails with saturation and captures the first failing vector.
module add_sub_result_checker
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned NUM_VEC = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_out,
  input  logic             overflow,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             fail_seen,
  output logic             ff_mode,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [WIDTH-1:0] ff_result,
  output logic [WIDTH-1:0] ff_expect
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] exp_res;
  logic             exp_c, exp_v;
  logic             match, start_ok, count_en, last_vec;
  logic [CNT_W-1:0] vec_inc;

  logic [CNT_W-1:0] vec_q, vec_d, pass_q, pass_d, fail_q, fail_d;
  logic             fail_seen_q, fail_seen_d, ff_mode_q, ff_mode_d;
  logic [WIDTH-1:0] ff_a_q, ff_a_d, ff_b_q, ff_b_d;
  logic [WIDTH-1:0] ff_result_q, ff_result_d, ff_expect_q, ff_expect_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  add_sub_golden #(.WIDTH(WIDTH)) u_golden (
    .a       (a),
    .b       (b),
    .mode    (mode),
    .exp_res (exp_res),
    .exp_c   (exp_c),
    .exp_v   (exp_v)
  );

  always_comb begin
    match    = (result == exp_res) && (carry_out == exp_c) && (overflow == exp_v);
    start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    count_en = in_valid && (state_q == ST_RUN);
    vec_inc  = sat_inc(vec_q);
    last_vec = count_en && (NUM_VEC != 0) && (32'(vec_inc) == NUM_VEC);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)             state_d = ST_RUN;
      ST_RUN:  if (stop || last_vec)  state_d = ST_DONE;
      ST_DONE: if (start)             state_d = ST_RUN;
      default:                        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == ST_RUN);
    done     = (state_q == ST_DONE);
    all_pass = done && (fail_q == '0) && (vec_q != '0);
  end

  always_comb begin
    vec_d       = vec_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    fail_seen_d = fail_seen_q;
    ff_mode_d   = ff_mode_q;
    ff_a_d      = ff_a_q;
    ff_b_d      = ff_b_q;
    ff_result_d = ff_result_q;
    ff_expect_d = ff_expect_q;
    if (start_ok) begin
      vec_d       = '0;
      pass_d      = '0;
      fail_d      = '0;
      fail_seen_d = 1'b0;
      ff_mode_d   = 1'b0;
      ff_a_d      = '0;
      ff_b_d      = '0;
      ff_result_d = '0;
      ff_expect_d = '0;
    end else if (count_en) begin
      vec_d = vec_inc;
      if (match) begin
        pass_d = sat_inc(pass_q);
      end else begin
        fail_d = sat_inc(fail_q);
        if (!fail_seen_q) begin
          fail_seen_d = 1'b1;
          ff_mode_d   = mode;
          ff_a_d      = a;
          ff_b_d      = b;
          ff_result_d = result;
          ff_expect_d = exp_res;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q       <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      fail_seen_q <= 1'b0;
      ff_mode_q   <= 1'b0;
      ff_a_q      <= '0;
      ff_b_q      <= '0;
      ff_result_q <= '0;
      ff_expect_q <= '0;
    end else begin
      vec_q       <= vec_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_seen_q <= fail_seen_d;
      ff_mode_q   <= ff_mode_d;
      ff_a_q      <= ff_a_d;
      ff_b_q      <= ff_b_d;
      ff_result_q <= ff_result_d;
      ff_expect_q <= ff_expect_d;
    end
  end

  assign vec_count  = vec_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign fail_seen  = fail_seen_q;
  assign ff_mode    = ff_mode_q;
  assign ff_a       = ff_a_q;
  assign ff_b       = ff_b_q;
  assign ff_result  = ff_result_q;
  assign ff_expect  = ff_expect_q;

endmodule

// File: tb/tb_add_sub_result_checker.sv
// Directed bench: default checker (NUM_VEC=6) plus a narrow unbounded one for saturation.
module tb_add_sub_result_checker;

  logic       clk = 1'b0;
  logic       rst, start, stop, in_valid, start_b, stop_b, in_valid_b;
  logic       mode, carry_out, overflow;
  logic [3:0] a, b, result;

  logic       busy, done, all_pass, fail_seen, ff_mode;
  logic [7:0] vec_count, pass_count, fail_count;
  logic [3:0] ff_a, ff_b, ff_result, ff_expect;

  logic       busy_b, done_b, all_pass_b, fail_seen_b, ff_mode_b;
  logic [1:0] vec_count_b, pass_count_b, fail_count_b;
  logic [3:0] ff_a_b, ff_b_b, ff_result_b, ff_expect_b;

  int n_vec = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  add_sub_result_checker #(.WIDTH(4), .CNT_W(8), .NUM_VEC(6)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .mode(mode), .a(a), .b(b), .result(result), .carry_out(carry_out), .overflow(overflow),
    .busy(busy), .done(done), .all_pass(all_pass), .vec_count(vec_count),
    .pass_count(pass_count), .fail_count(fail_count), .fail_seen(fail_seen),
    .ff_mode(ff_mode), .ff_a(ff_a), .ff_b(ff_b), .ff_result(ff_result), .ff_expect(ff_expect)
  );

  add_sub_result_checker #(.WIDTH(4), .CNT_W(2), .NUM_VEC(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .in_valid(in_valid_b),
    .mode(mode), .a(a), .b(b), .result(result), .carry_out(carry_out), .overflow(overflow),
    .busy(busy_b), .done(done_b), .all_pass(all_pass_b), .vec_count(vec_count_b),
    .pass_count(pass_count_b), .fail_count(fail_count_b), .fail_seen(fail_seen_b),
    .ff_mode(ff_mode_b), .ff_a(ff_a_b), .ff_b(ff_b_b), .ff_result(ff_result_b),
    .ff_expect(ff_expect_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of in_valid on checker A (sel=0) or B (sel=1); stp raises stop alongside.
  task automatic apply(input logic sel, input logic md, input logic [3:0] aa, input logic [3:0] bb,
                       input logic [3:0] rr, input logic cc, input logic vv, input logic stp);
    mode = md; a = aa; b = bb; result = rr; carry_out = cc; overflow = vv;
    if (sel) begin in_valid_b = 1'b1; stop_b = stp; end
    else     begin in_valid   = 1'b1; stop   = stp; end
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid_b = 1'b0; stop = 1'b0; stop_b = 1'b0;
    n_vec++;
  endtask

  task automatic pulse_start(input logic sel);
    if (sel) start_b = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    start_b = 1'b0; stop_b = 1'b0; in_valid_b = 1'b0;
    mode = 1'b0; a = '0; b = '0; result = '0; carry_out = 1'b0; overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_vec", 32'(vec_count), 32'd0);
    check("rst_fail_seen", 32'(fail_seen), 32'd0);

    apply(1'b0, 1'b0, 4'b0011, 4'b0001, 4'b0100, 1'b0, 1'b0, 1'b0);
    check("idle_ignore_vec", 32'(vec_count), 32'd0);

    pulse_start(1'b0);
    check("start_busy", 32'(busy), 32'd1);
    apply(1'b0, 1'b0, 4'b0011, 4'b0001, 4'b0100, 1'b0, 1'b0, 1'b0);
    check("t1_pass", 32'(pass_count), 32'd1);
    check("t1_fail", 32'(fail_count), 32'd0);
    apply(1'b0, 1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0);
    check("t2_pass", 32'(pass_count), 32'd2);
    apply(1'b0, 1'b0, 4'b0100, 4'b0100, 4'b1000, 1'b0, 1'b0, 1'b0);
    check("t2_fail", 32'(fail_count), 32'd1);
    check("t2_fail_seen", 32'(fail_seen), 32'd1);
    check("t2_ff_a", 32'(ff_a), 32'h4);
    check("t2_ff_b", 32'(ff_b), 32'h4);
    check("t2_ff_expect", 32'(ff_expect), 32'h8);
    check("t2_ff_result", 32'(ff_result), 32'h8);
    check("t2_ff_mode", 32'(ff_mode), 32'd0);

    apply(1'b0, 1'b1, 4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0);
    check("t3_busy_at5", 32'(busy), 32'd1);
    check("t3_pass_at5", 32'(pass_count), 32'd4);
    apply(1'b0, 1'b1, 4'b1000, 4'b0111, 4'b0001, 1'b1, 1'b1, 1'b0);
    check("t3_done", 32'(done), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_vec", 32'(vec_count), 32'd6);
    check("t3_pass", 32'(pass_count), 32'd5);
    check("t3_all_pass", 32'(all_pass), 32'd0);
    apply(1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("t3_frozen", 32'(vec_count), 32'd6);

    pulse_start(1'b0);
    check("t4_cleared_vec", 32'(vec_count), 32'd0);
    check("t4_cleared_seen", 32'(fail_seen), 32'd0);
    check("t4_cleared_ff_a", 32'(ff_a), 32'd0);
    apply(1'b0, 1'b0, 4'b0010, 4'b0011, 4'b0101, 1'b0, 1'b0, 1'b0);
    pulse_start(1'b0);
    check("t4_start_in_run", 32'(vec_count), 32'd1);
    apply(1'b0, 1'b1, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0, 1'b1);
    check("t4_done", 32'(done), 32'd1);
    check("t4_vec", 32'(vec_count), 32'd2);
    check("t4_all_pass", 32'(all_pass), 32'd1);
    apply(1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b0);
    check("t4_frozen_vec", 32'(vec_count), 32'd2);
    check("t4_frozen_fail", 32'(fail_count), 32'd0);

    pulse_start(1'b0);
    apply(1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0011, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
    check("t5_vec_before", 32'(vec_count), 32'd3);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_vec", 32'(vec_count), 32'd0);
    check("t5_fail", 32'(fail_count), 32'd0);
    check("t5_ff_a", 32'(ff_a), 32'd0);
    apply(1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b0);
    check("t5_ignore", 32'(vec_count), 32'd0);

    pulse_start(1'b1);
    apply(1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 4'b0011, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 4'b0101, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 4'b0110, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("t6_fail_sat", 32'(fail_count_b), 32'd3);
    check("t6_vec_sat", 32'(vec_count_b), 32'd3);
    check("t6_pass", 32'(pass_count_b), 32'd0);
    check("t6_still_busy", 32'(busy_b), 32'd1);
    check("t6_ff_a", 32'(ff_a_b), 32'h1);
    check("t6_ff_b", 32'(ff_b_b), 32'h1);
    check("t6_ff_expect", 32'(ff_expect_b), 32'h2);
    check("t6_ff_result", 32'(ff_result_b), 32'h0);
    stop_b = 1'b1;
    @(posedge clk); #1;
    stop_b = 1'b0;
    check("t6_done", 32'(done_b), 32'd1);
    check("t6_all_pass", 32'(all_pass_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
